// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between instruction and data requesters
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    imem_req_i,
  input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
  output logic [DATA_WIDTH-1:0]   imem_rdata_o,
  output logic                    imem_ready_o,
  input  logic                    dmem_read_i,
  input  logic                    dmem_write_i,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
  output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
  output logic                    dmem_ready_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    protocol_err_o
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state_q, state_d;
  logic lg_q, lg_d;
  logic ip_q, ip_d, dp_q, dp_d, dwe_q, dwe_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] ia_q, ia_d, da_q, da_d;
  logic [DATA_WIDTH-1:0] dwd_q, dwd_d, irdata_q, drdata_q;
  logic [DATA_WIDTH/8-1:0] dws_q, dws_d;
  logic irdy_q, drdy_q;
  logic ack_i, ack_d, d_pulse, d_bad;
  assign ack_i = (state_q == BUSY_I) && mem_ack_i;
  assign ack_d = (state_q == BUSY_D) && mem_ack_i;
  assign d_pulse = dmem_read_i | dmem_write_i;
  assign d_bad = (dmem_read_i & dmem_write_i) | (d_pulse & dp_q);
  always_comb begin
    ip_d = ack_i ? 1'b0 : ip_q;
    ia_d = ia_q;
    dp_d = ack_d ? 1'b0 : dp_q;
    dwe_d = dwe_q;
    da_d = da_q;
    dwd_d = dwd_q;
    dws_d = dws_q;
    err_d = err_q | (imem_req_i & ip_q) | d_bad;
    if (imem_req_i && !ip_q) begin
      ip_d = 1'b1;
      ia_d = imem_addr_i;
    end
    if (d_pulse && !d_bad) begin
      dp_d = 1'b1;
      dwe_d = dmem_write_i;
      da_d = dmem_addr_i;
      dwd_d = dmem_wdata_i;
      dws_d = dmem_wstrb_i;
    end
  end
  always_comb begin
    state_d = state_q;
    lg_d = lg_q;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    mem_addr_o = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    case (state_q)
      IDLE: begin
        // Arbitrate on next-cycle pending so a fresh pulse reaches the port one cycle later
        if (ip_d || dp_d) begin
          lg_d = (ip_d && dp_d) ? ~lg_q : dp_d;
          state_d = lg_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I: begin
        mem_req_o = 1'b1;
        mem_addr_o = ia_q;
        mem_wstrb_o = '1;
        state_d = mem_ack_i ? IDLE : BUSY_I;
      end
      BUSY_D: begin
        mem_req_o = 1'b1;
        mem_we_o = dwe_q;
        mem_addr_o = da_q;
        mem_wdata_o = dwd_q;
        mem_wstrb_o = dws_q;
        state_d = mem_ack_i ? IDLE : BUSY_D;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lg_q <= 1'b0;
      ip_q <= 1'b0;
      ia_q <= '0;
      dp_q <= 1'b0;
      dwe_q <= 1'b0;
      da_q <= '0;
      dwd_q <= '0;
      dws_q <= '0;
      err_q <= 1'b0;
      irdy_q <= 1'b0;
      drdy_q <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q <= state_d;
      lg_q <= lg_d;
      ip_q <= ip_d;
      ia_q <= ia_d;
      dp_q <= dp_d;
      dwe_q <= dwe_d;
      da_q <= da_d;
      dwd_q <= dwd_d;
      dws_q <= dws_d;
      err_q <= err_d;
      irdy_q <= ack_i;
      drdy_q <= ack_d;
      irdata_q <= ack_i ? mem_rdata_i : '0;
      drdata_q <= (ack_d && !dwe_q) ? mem_rdata_i : '0;
    end
  end
  assign imem_ready_o = irdy_q;
  assign imem_rdata_o = irdata_q;
  assign dmem_ready_o = drdy_q;
  assign dmem_rdata_o = drdata_q;
  assign protocol_err_o = err_q;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; wstrb width = DATA_WIDTH/8.
REQ-003 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req_i  in  1  instruction-fetch request, single-cycle pulse.
REQ-006 SHALL have port imem_addr_i  in  ADDR_WIDTH  fetch address, valid with imem_req_i.
REQ-007 SHALL have port imem_rdata_o  out  DATA_WIDTH  fetched instruction, valid with imem_ready_o.
REQ-008 SHALL have port imem_ready_o  out  1  fetch completion, single-cycle pulse.
REQ-009 SHALL have port dmem_read_i / dmem_write_i  in  1 each  data read/write request pulses.
REQ-010 SHALL have port dmem_addr_i, dmem_wdata_i, dmem_wstrb_i  in  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  data request fields, valid with the pulse.
REQ-011 SHALL have port dmem_rdata_o  out  DATA_WIDTH and dmem_ready_o  out  1  data completion, single-cycle pulse for reads and writes.
REQ-012 SHALL have port mem_req_o, mem_we_o  out  1; mem_addr_o  out  ADDR_WIDTH; mem_wdata_o  out  DATA_WIDTH; mem_wstrb_o  out  DATA_WIDTH/8  shared memory port.
REQ-013 SHALL have port mem_ack_i  in  1 and mem_rdata_i  in  DATA_WIDTH  single-cycle completion from memory, rdata valid with ack.
REQ-014 SHALL have port protocol_err_o  out  1  sticky protocol-violation flag.

Function
REQ-015 SHALL capture each request pulse into a per-requester pending register (I, D) with its fields; arbitration SHALL use only pending registers.
REQ-016 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-017 IDLE: if only I pending -> BUSY_I; only D pending -> BUSY_D; both -> requester not equal to last_grant_r (round-robin); none -> IDLE.
REQ-018 last_grant_r SHALL update to the granted requester on every IDLE->BUSY transition.
REQ-019 In BUSY_x: mem_req_o=1 and mem_addr/we/wdata/wstrb driven from x's pending register, held stable until mem_ack_i; mem_we_o=1 only for D writes; wstrb=all-ones and wdata=0 for I.
REQ-020 In IDLE mem_req_o=0, mem_we_o=0, other mem outputs 0.
REQ-021 On mem_ack_i in BUSY_x: clear x pending, state -> IDLE; x_ready_o pulses the following cycle with x_rdata_o = registered mem_rdata_i (writes: dmem_rdata_o = 0).
REQ-022 Latency: pulse in cycle N with port idle -> mem_req_o=1 in N+1; ack in M -> ready pulse in M+1; mem_req_o=0 for at least one cycle between transactions.
REQ-023 *_rdata_o SHALL be 0 whenever the matching ready is 0.
REQ-024 mem_ack_i in IDLE SHALL be ignored (no ready pulse, no state change).
REQ-025 A request pulse arriving while the same requester is pending (including the ack cycle), or dmem_read_i and dmem_write_i together, SHALL be dropped and set protocol_err_o.
REQ-026 Simultaneous imem and dmem pulses in one cycle SHALL both be captured.
REQ-027 A pulse from the other requester during BUSY SHALL be captured and served after the current transaction.

Reset
REQ-028 On rst_n low: state IDLE, pendings cleared, last_grant_r=I, all outputs 0, protocol_err_o=0, immediately and asynchronously.
REQ-029 Reset mid-transaction SHALL abandon it; no ready pulse after reset release for the abandoned request.

Verification
REQ-030 imem_req_i at cycle 0, addr 0x100; ack cycle 3, rdata 0x00500093 -> mem_req_o cycles 1-3, imem_ready_o cycle 4 with 0x00500093.
REQ-031 imem_req_i and dmem_read_i same cycle after reset -> D granted first (last_grant=I), I granted next, mem_req_o low one cycle between.
REQ-032 dmem_write_i addr 0x2004, wdata 0xDEADBEEF, wstrb 0x3 -> mem_we_o=1 with same fields; dmem_ready_o pulse, dmem_rdata_o=0.
REQ-033 Second imem_req_i while I pending -> dropped, protocol_err_o=1 until reset; single imem_ready_o.
REQ-034 mem_ack_i asserted in IDLE -> no ready pulse, state unchanged.
REQ-035 rst_n low during BUSY_D -> outputs 0 immediately; no dmem_ready_o after release.
